// File: rtl/bcd_to_bin.sv
// bcd_to_bin: three-digit BCD to 8-bit binary converter.
// Reverse double dabble, one bit per clock, behind a start/busy/done handshake.
// Non-decimal digits and values above 255 raise err and force bin to zero.
module bcd_to_bin (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [19:0] work;       // {h, t, o, b}
  logic        digit_bad;

  logic [19:0] shifted;
  logic [19:0] next_work;
  logic        overflow;
  logic        result_bad;

  // Digit correction after a right shift: a digit of 8 or more received a
  // carried-in tens weight of 8 that is really worth 5, so take 3 back out.
  function automatic logic [3:0] adjust(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  // One reverse double dabble iteration on the work register.
  always_comb begin
    shifted    = {1'b0, work[19:1]};
    next_work  = {adjust(shifted[19:16]), adjust(shifted[15:12]),
                  adjust(shifted[11:8]), shifted[7:0]};
    overflow   = |next_work[19:8];
    result_bad = digit_bad | overflow;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      digit_bad <= 1'b0;
      bin       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work      <= {hundreds, tens, ones, 8'd0};
            digit_bad <= (hundreds > 4'd9) | (tens > 4'd9) | (ones > 4'd9);
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          work <= next_work;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= result_bad;
            bin   <= result_bad ? 8'd0 : next_work[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: a reference tracker pushes the expected
// decimal-arithmetic result at every accepting edge; a monitor checks the
// handshake every cycle and pops/compares on each done pulse.
module tb_bcd_to_bin;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [8:0] expq[$];      // {err, bin}
  int         tcnt = 0;     // cycles of conversion remaining in the reference
  logic       exp_done = 1'b0;
  logic [7:0] last_bin = 8'd0;
  logic       last_err = 1'b0;

  bcd_to_bin dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain decimal arithmetic.
  function automatic logic [8:0] model(input int h, input int t, input int o);
    int  v;
    logic e;
    v = h * 100 + t * 10 + o;
    e = (h > 9) || (t > 9) || (o > 9) || (v > 255);
    return e ? {1'b1, 8'd0} : {1'b0, v[7:0]};
  endfunction

  // Reference handshake: a start seen while idle is accepted and takes 8 more edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expq.delete();
      tcnt     = 0;
      exp_done = 1'b0;
    end else begin
      exp_done = (tcnt == 1);
      if (tcnt == 0) begin
        if (start) begin
          expq.push_back(model(hundreds, tens, ones));
          tcnt = 8;
        end
      end else begin
        tcnt = tcnt - 1;
      end
    end
  end

  // Monitor: handshake and held-output checks every cycle, scoreboard pop on done.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      last_bin = 8'd0;
      last_err = 1'b0;
    end
    checks++;
    if (busy !== (tcnt != 0)) begin
      errors++;
      $display("FAIL busy: got %b want %b", busy, (tcnt != 0));
    end
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL done: got %b want %b", done, exp_done);
    end
    checks++;
    if (busy && done) begin
      errors++;
      $display("FAIL busy_and_done: got busy=%b done=%b want not both", busy, done);
    end
    if (done === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard want no done");
      end else begin
        e = expq.pop_front();
        last_bin = e[7:0];
        last_err = e[8];
      end
    end
    checks++;
    if (bin !== last_bin || err !== last_err) begin
      errors++;
      $display("FAIL result: got bin=%h err=%b want bin=%h err=%b",
               bin, err, last_bin, last_err);
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done within 20 cycles want done");
    end
  endtask

  task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    hundreds = h;
    tens     = t;
    ones     = o;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    hundreds = 4'($urandom);
    tens     = 4'($urandom);
    ones     = 4'($urandom);
    wait_done();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    hundreds = '0;
    tens     = '0;
    ones     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bin !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got bin=%h busy=%b done=%b err=%b want all zero",
               bin, busy, done, err);
    end
    rst_n = 1'b1;

    // Directed values including both range boundaries and a bad digit.
    convert(4'd2, 4'd5, 4'd5);
    convert(4'd0, 4'd0, 4'd0);
    convert(4'd1, 4'd2, 4'd8);
    convert(4'd0, 4'd9, 4'd9);
    convert(4'd1, 4'd0, 4'd0);
    convert(4'd2, 4'd5, 4'd6);
    convert(4'd9, 4'd9, 4'd9);
    convert(4'd0, 4'hA, 4'd3);
    convert(4'hF, 4'hF, 4'hF);

    // start held high with inputs changing every cycle.
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      start    = 1'b1;
      hundreds = 4'($urandom_range(0, 2));
      tens     = 4'($urandom_range(0, 9));
      ones     = 4'($urandom_range(0, 9));
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();

    // Reset in the middle of a conversion.
    convert(4'd3, 4'd0, 4'd0);
    @(negedge clk);
    hundreds = 4'd1;
    tens     = 4'd2;
    ones     = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bin !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got bin=%h busy=%b done=%b err=%b want all zero",
               bin, busy, done, err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    convert(4'd0, 4'd4, 4'd2);

    // Random digits, including non-decimal ones.
    for (int i = 0; i < 150; i++)
      convert(4'($urandom), 4'($urandom), 4'($urandom));

    // Exhaustive sweep of every valid triple.
    for (int h = 0; h < 10; h++)
      for (int t = 0; t < 10; t++)
        for (int o = 0; o < 10; o++)
          convert(4'(h), 4'(t), 4'(o));

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending results want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
